// File: rtl/write_back_pipe.sv
// write_back_pipe: registered write-back stage between memory stage and register file.
// Selects the destination value (ALU / load / link PC / upper immediate) and extracts
// and extends load lanes. Stalls upstream while late load data is outstanding.
// Counts retired instructions.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   upstream handshake
//   in_sel, in_rd, in_rd_we, in_alu, in_pc_link, in_uimm,
//   in_ld_funct3, in_ld_off   instruction fields
//   mem_rvalid, mem_rdata     load return data
//   rf_we, rf_waddr, rf_wdata register-file write port
//   ld_err, retire_cnt        error pulse, retire counter
module write_back_pipe #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 64,
    parameter int OW    = $clog2(XLEN/8)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [AW-1:0]    in_rd,
    input  logic             in_rd_we,
    input  logic [XLEN-1:0]  in_alu,
    input  logic [XLEN-1:0]  in_pc_link,
    input  logic [XLEN-1:0]  in_uimm,
    input  logic [2:0]       in_ld_funct3,
    input  logic [OW-1:0]    in_ld_off,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             rf_we,
    output logic [AW-1:0]    rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             ld_err,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]      r_state;
    logic [AW-1:0]   r_rd;
    logic            r_rd_we;
    logic [2:0]      r_f3;
    logic [OW-1:0]   r_off;

    logic            r_rf_we;
    logic [AW-1:0]   r_rf_waddr;
    logic [XLEN-1:0] r_rf_wdata;
    logic            r_ld_err;
    logic [CNT_W-1:0] r_cnt;

    logic            w_wait;
    logic [1:0]      w_sel;
    logic [AW-1:0]   w_rd;
    logic            w_rd_we;
    logic [2:0]      w_f3;
    logic [OW-1:0]   w_off;
    logic            w_commit;
    logic            w_go_wait;
    logic [XLEN-1:0] w_lane;
    logic [XLEN-1:0] w_up;
    logic [6:0]      w_sh;
    logic [XLEN-1:0] w_ld_data;
    logic            w_mis;
    logic            w_unsup;
    logic            w_err;
    logic [XLEN-1:0] w_val;

    assign w_wait   = (r_state == S_WAIT);
    assign in_ready = (r_state == S_IDLE);

    // In WAIT the pending load's latched fields drive the datapath.
    assign w_sel   = w_wait ? 2'b01   : in_sel;
    assign w_rd    = w_wait ? r_rd    : in_rd;
    assign w_rd_we = w_wait ? r_rd_we : in_rd_we;
    assign w_f3    = w_wait ? r_f3    : in_ld_funct3;
    assign w_off   = w_wait ? r_off   : in_ld_off;

    assign w_commit = w_wait ? mem_rvalid
                    : (in_valid && ((in_sel != 2'b01) || mem_rvalid));
    assign w_go_wait = !w_wait && in_valid && (in_sel == 2'b01) && !mem_rvalid;

    assign w_lane = mem_rdata >> {w_off, 3'b000};

    // Extension by shifting the lane to the top, then shifting back
    // logically (unsigned) or arithmetically (signed).
    always_comb begin
        w_sh    = 7'd0;
        w_mis   = 1'b0;
        w_unsup = 1'b0;
        unique case (w_f3[1:0])
            2'b00: w_sh = 7'(XLEN - 8);
            2'b01: begin
                w_sh  = 7'(XLEN - 16);
                w_mis = w_off[0];
            end
            2'b10: begin
                w_sh  = 7'(XLEN - 32);
                w_mis = (w_off[1:0] != 2'b00);
            end
            2'b11: begin
                w_sh    = 7'd0;
                w_mis   = (w_off != '0);
                w_unsup = (XLEN == 32);
            end
        endcase
        if (w_f3 == 3'b111) w_unsup = 1'b1;
        if ((XLEN == 32) && (w_f3 == 3'b110)) w_unsup = 1'b1;
    end

    assign w_up      = w_lane << w_sh;
    assign w_ld_data = w_f3[2] ? (w_up >> w_sh)
                               : $unsigned($signed(w_up) >>> w_sh);
    assign w_err     = (w_sel == 2'b01) && (w_mis || w_unsup);

    always_comb begin
        w_val = in_alu;
        unique case (1'b1)
            (w_sel == 2'b00): w_val = in_alu;
            (w_sel == 2'b01): w_val = w_ld_data;
            (w_sel == 2'b10): w_val = in_pc_link;
            (w_sel == 2'b11): w_val = in_uimm;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rd       <= '0;
            r_rd_we    <= 1'b0;
            r_f3       <= '0;
            r_off      <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_ld_err   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_rf_we  <= w_commit && w_rd_we && (w_rd != '0) && !w_err;
            r_ld_err <= w_commit && w_err;
            if (w_commit) begin
                r_rf_waddr <= w_rd;
                r_rf_wdata <= w_err ? '0 : w_val;
                r_cnt      <= r_cnt + CNT_W'(1);
            end
            if (w_go_wait) begin
                r_state <= S_WAIT;
                r_rd    <= in_rd;
                r_rd_we <= in_rd_we;
                r_f3    <= in_ld_funct3;
                r_off   <= in_ld_off;
            end else if (w_wait && mem_rvalid) begin
                r_state <= S_IDLE;
            end
        end
    end

    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;
    assign ld_err     = r_ld_err;
    assign retire_cnt = r_cnt;

endmodule
